// File: rtl/cache_control_pkg.sv
// Shared types for the cache controller: FSM state encoding and datapath mux-select values.
package cache_control_pkg;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  localparam logic ADDR_CPU    = 1'b0;
  localparam logic ADDR_VICTIM = 1'b1;
  localparam logic SRC_PMEM    = 1'b0;
  localparam logic SRC_CPU     = 1'b1;

  // LRU points away from the way just used
  function automatic logic other_way(input logic way);
    return ~way;
  endfunction

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter used for the cache performance statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: hold at all-ones once reached
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Two-way cache controller FSM (CHECK / WRITEBACK / ALLOCATE) with combinational datapath controls.
// Optional hit/miss/writeback counters are built when CACHE_CTRL_PERF_EN is defined.
module cache_control
  import cache_control_pkg::*;
#(
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  mem_resp,
  input  logic                  hit0,
  input  logic                  hit1,
  input  logic                  lru,
  input  logic                  victim_dirty,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic                  pmem_resp,
  output logic                  data_sel,
  output logic                  mem_addr_sel,
  output logic                  load_way0,
  output logic                  load_way1,
  output logic                  load_src,
  output logic                  set_dirty,
  output logic                  clr_dirty,
  output logic                  lru_load,
  output logic                  lru_in
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] hit_cnt,
  output logic [PERF_CNT_W-1:0] miss_cnt,
  output logic [PERF_CNT_W-1:0] wb_cnt
`endif
);

  state_e state_q;
  state_e state_d;
  logic   req_s;
  logic   hit_s;
  logic   hit_way_s;

  assign req_s     = mem_read | mem_write;
  assign hit_s     = hit0 | hit1;
  // way0 wins when both ways report a hit
  assign hit_way_s = ~hit0;

  // next state and datapath controls; everything is forced low while reset is asserted
  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    data_sel     = 1'b0;
    mem_addr_sel = ADDR_CPU;
    load_way0    = 1'b0;
    load_way1    = 1'b0;
    load_src     = SRC_PMEM;
    set_dirty    = 1'b0;
    clr_dirty    = 1'b0;
    lru_load     = 1'b0;
    lru_in       = 1'b0;
    if (!rst_n) begin
      state_d = CHECK;
    end else begin
      case (state_q)
        CHECK: begin
          if (req_s && hit_s) begin
            mem_resp = 1'b1;
            data_sel = hit_way_s;
            lru_load = 1'b1;
            lru_in   = other_way(hit_way_s);
            if (mem_write) begin
              load_way0 = ~hit_way_s;
              load_way1 = hit_way_s;
              load_src  = SRC_CPU;
              set_dirty = 1'b1;
            end else begin
              load_src  = SRC_PMEM;
            end
          end else if (req_s) begin
            state_d = victim_dirty ? WRITEBACK : ALLOCATE;
          end else begin
            state_d = CHECK;
          end
        end
        WRITEBACK: begin
          pmem_write   = 1'b1;
          mem_addr_sel = ADDR_VICTIM;
          data_sel     = lru;
          if (pmem_resp) begin
            state_d = ALLOCATE;
          end else begin
            state_d = WRITEBACK;
          end
        end
        ALLOCATE: begin
          pmem_read    = 1'b1;
          mem_addr_sel = ADDR_CPU;
          if (pmem_resp) begin
            load_way0 = ~lru;
            load_way1 = lru;
            load_src  = SRC_PMEM;
            clr_dirty = 1'b1;
            state_d   = CHECK;
          end else begin
            state_d   = ALLOCATE;
          end
        end
        default: begin
          state_d = CHECK;
        end
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CHECK;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic hit_evt_s;
  logic miss_evt_s;
  logic wb_evt_s;

  assign hit_evt_s  = mem_resp;
  assign miss_evt_s = rst_n & (state_q == CHECK) & req_s & ~hit_s;
  assign wb_evt_s   = rst_n & (state_q == WRITEBACK) & pmem_resp;

  sat_counter #(.W(PERF_CNT_W)) u_hit_cnt (
    .clk(clk), .rst_n(rst_n), .inc(hit_evt_s), .count(hit_cnt)
  );
  sat_counter #(.W(PERF_CNT_W)) u_miss_cnt (
    .clk(clk), .rst_n(rst_n), .inc(miss_evt_s), .count(miss_cnt)
  );
  sat_counter #(.W(PERF_CNT_W)) u_wb_cnt (
    .clk(clk), .rst_n(rst_n), .inc(wb_evt_s), .count(wb_cnt)
  );
`endif

endmodule
